// File: rtl/delay_sweep_scheduler.sv
// Linear inter-pulse delay sweep sequencer for the pulse generator.
// Optional feature: define SWEEP_REPEAT_EN to loop the sweep until abort.
`timescale 1ns/1ps
module delay_sweep_scheduler (
    input  logic        clk_pll,
    input  logic        reset,
    input  logic        start,
    input  logic        abort,
    input  logic [15:0] cfg_del0,
    input  logic [15:0] cfg_step,
    input  logic [7:0]  cfg_npts,
    input  logic [7:0]  cfg_shots,
    input  logic        period_tick,
    output logic [15:0] del,
    output logic        load,
    output logic [7:0]  point_idx,
    output logic        busy,
    output logic        done,
    output logic        overflow
);

    typedef enum logic [1:0] {IDLE = 2'd0, ARM = 2'd1, RUN = 2'd2, DONE = 2'd3} state_t;

    state_t      state_q, state_d;
    logic [15:0] del_q, del_d;
    logic [15:0] step_q, step_d;
    logic [7:0]  idx_q, idx_d;
    logic [7:0]  shot_q, shot_d;
    logic [7:0]  npts_last_q, npts_last_d;
    logic [7:0]  shots_last_q, shots_last_d;
    logic        load_q, load_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        ovf_q, ovf_d;
    logic [16:0] sum_s;
`ifdef SWEEP_REPEAT_EN
    logic [15:0] del0_q, del0_d;
`endif

    assign sum_s = {1'b0, del_q} + {1'b0, step_q};

    // Next-state and registered-output decode; abort outranks tick, tick outranks start
    always_comb begin
        state_d      = state_q;
        del_d        = del_q;
        step_d       = step_q;
        idx_d        = idx_q;
        shot_d       = shot_q;
        npts_last_d  = npts_last_q;
        shots_last_d = shots_last_q;
        load_d       = 1'b0;
        busy_d       = busy_q;
        done_d       = 1'b0;
        ovf_d        = ovf_q;
`ifdef SWEEP_REPEAT_EN
        del0_d       = del0_q;
`endif
        case (state_q)
            IDLE: begin
                if (start && !abort) begin
                    // Zero counts behave as one; store the last valid index instead
                    npts_last_d  = (cfg_npts == 8'd0) ? 8'd0 : cfg_npts - 8'd1;
                    shots_last_d = (cfg_shots == 8'd0) ? 8'd0 : cfg_shots - 8'd1;
                    step_d       = cfg_step;
                    del_d        = cfg_del0;
`ifdef SWEEP_REPEAT_EN
                    del0_d       = cfg_del0;
`endif
                    idx_d        = 8'd0;
                    shot_d       = 8'd0;
                    ovf_d        = 1'b0;
                    load_d       = 1'b1;
                    busy_d       = 1'b1;
                    state_d      = ARM;
                end else begin
                    state_d = IDLE;
                end
            end
            ARM: begin
                if (abort) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end else if (period_tick) begin
                    shot_d  = 8'd0;
                    state_d = RUN;
                end else begin
                    state_d = ARM;
                end
            end
            RUN: begin
                if (abort) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end else if (period_tick) begin
                    if (shot_q < shots_last_q) begin
                        shot_d = shot_q + 8'd1;
                    end else if (idx_q < npts_last_q) begin
                        idx_d  = idx_q + 8'd1;
                        shot_d = 8'd0;
                        load_d = 1'b1;
                        if (sum_s[16]) begin
                            del_d = 16'hFFFF;
                            ovf_d = 1'b1;
                        end else begin
                            del_d = sum_s[15:0];
                        end
                    end else begin
                        done_d = 1'b1;
`ifdef SWEEP_REPEAT_EN
                        del_d  = del0_q;
                        idx_d  = 8'd0;
                        shot_d = 8'd0;
                        ovf_d  = 1'b0;
                        load_d = 1'b1;
`else
                        state_d = DONE;
`endif
                    end
                end else begin
                    state_d = RUN;
                end
            end
            DONE: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge clk_pll) begin
        if (!reset) begin
            state_q      <= IDLE;
            del_q        <= 16'd0;
            step_q       <= 16'd0;
            idx_q        <= 8'd0;
            shot_q       <= 8'd0;
            npts_last_q  <= 8'd0;
            shots_last_q <= 8'd0;
            load_q       <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            ovf_q        <= 1'b0;
`ifdef SWEEP_REPEAT_EN
            del0_q       <= 16'd0;
`endif
        end else begin
            state_q      <= state_d;
            del_q        <= del_d;
            step_q       <= step_d;
            idx_q        <= idx_d;
            shot_q       <= shot_d;
            npts_last_q  <= npts_last_d;
            shots_last_q <= shots_last_d;
            load_q       <= load_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            ovf_q        <= ovf_d;
`ifdef SWEEP_REPEAT_EN
            del0_q       <= del0_d;
`endif
        end
    end

    assign del       = del_q;
    assign load      = load_q;
    assign point_idx = idx_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_delay_sweep_scheduler.sv
// Table-driven bench for delay_sweep_scheduler; expected outputs queued per applied vector.
`timescale 1ns/1ps
module tb_delay_sweep_scheduler;

    typedef struct {
        logic        rst_n;
        logic        start;
        logic        abort;
        logic        tick;
        logic [15:0] del0;
        logic [15:0] step;
        logic [7:0]  npts;
        logic [7:0]  shots;
        logic [15:0] e_del;
        logic        e_load;
        logic [7:0]  e_idx;
        logic        e_busy;
        logic        e_done;
        logic        e_ovf;
        string       name;
    } vec_t;

    logic        clk_pll = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [15:0] cfg_del0 = 16'd0;
    logic [15:0] cfg_step = 16'd0;
    logic [7:0]  cfg_npts = 8'd0;
    logic [7:0]  cfg_shots = 8'd0;
    logic        period_tick = 1'b0;
    logic [15:0] del;
    logic        load;
    logic [7:0]  point_idx;
    logic        busy;
    logic        done;
    logic        overflow;

    vec_t        vecs[$];
    vec_t        exp_q[$];
    logic [15:0] c_del0, c_step;
    logic [7:0]  c_npts, c_shots;
    int          errors = 0;
    int          checks = 0;
    int          load_seen = 0;
    int          load_expected = 0;
    int          load_back_to_back = 0;
    logic        load_prev = 1'b0;

    delay_sweep_scheduler dut (
        .clk_pll(clk_pll), .reset(reset), .start(start), .abort(abort),
        .cfg_del0(cfg_del0), .cfg_step(cfg_step), .cfg_npts(cfg_npts), .cfg_shots(cfg_shots),
        .period_tick(period_tick), .del(del), .load(load), .point_idx(point_idx),
        .busy(busy), .done(done), .overflow(overflow)
    );

    always #2.5 clk_pll = ~clk_pll;

    task automatic v(input string nm, input logic r, input logic s, input logic a, input logic t,
                     input logic [15:0] ed, input logic el, input logic [7:0] ei,
                     input logic eb, input logic edn, input logic eo);
        vec_t x;
        x.name = nm; x.rst_n = r; x.start = s; x.abort = a; x.tick = t;
        x.del0 = c_del0; x.step = c_step; x.npts = c_npts; x.shots = c_shots;
        x.e_del = ed; x.e_load = el; x.e_idx = ei; x.e_busy = eb; x.e_done = edn; x.e_ovf = eo;
        vecs.push_back(x);
    endtask

    initial begin
        vec_t e;
        c_del0 = 16'd0; c_step = 16'd0; c_npts = 8'd0; c_shots = 8'd0;
        v("reset0", 1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0);
        v("reset1", 1'b0, 1'b1, 1'b0, 1'b1, 16'd0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0);
        v("idle_tick", 1'b1, 1'b0, 1'b0, 1'b1, 16'd0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0);
`ifndef SWEEP_REPEAT_EN
        c_del0 = 16'd200; c_step = 16'd50; c_npts = 8'd3; c_shots = 8'd2;
        v("b_start", 1'b1, 1'b1, 1'b0, 1'b0, 16'd200, 1'b1, 8'd0, 1'b1, 1'b0, 1'b0);
        c_del0 = 16'd999; c_step = 16'd1; c_npts = 8'd9; c_shots = 8'd9;
        v("b_idle",  1'b1, 1'b0, 1'b0, 1'b0, 16'd200, 1'b0, 8'd0, 1'b1, 1'b0, 1'b0);
        v("b_t1",    1'b1, 1'b0, 1'b0, 1'b1, 16'd200, 1'b0, 8'd0, 1'b1, 1'b0, 1'b0);
        v("b_t2",    1'b1, 1'b0, 1'b0, 1'b1, 16'd200, 1'b0, 8'd0, 1'b1, 1'b0, 1'b0);
        v("b_t3",    1'b1, 1'b0, 1'b0, 1'b1, 16'd250, 1'b1, 8'd1, 1'b1, 1'b0, 1'b0);
        v("b_t4s",   1'b1, 1'b1, 1'b0, 1'b1, 16'd250, 1'b0, 8'd1, 1'b1, 1'b0, 1'b0);
        v("b_t5",    1'b1, 1'b0, 1'b0, 1'b1, 16'd300, 1'b1, 8'd2, 1'b1, 1'b0, 1'b0);
        v("b_t6",    1'b1, 1'b0, 1'b0, 1'b1, 16'd300, 1'b0, 8'd2, 1'b1, 1'b0, 1'b0);
        v("b_t7",    1'b1, 1'b0, 1'b0, 1'b1, 16'd300, 1'b0, 8'd2, 1'b1, 1'b1, 1'b0);
        v("b_end",   1'b1, 1'b0, 1'b0, 1'b0, 16'd300, 1'b0, 8'd2, 1'b0, 1'b0, 1'b0);
        c_del0 = 16'd7; c_step = 16'd3; c_npts = 8'd0; c_shots = 8'd0;
        v("z_start", 1'b1, 1'b1, 1'b0, 1'b0, 16'd7, 1'b1, 8'd0, 1'b1, 1'b0, 1'b0);
        v("z_t1",    1'b1, 1'b0, 1'b0, 1'b1, 16'd7, 1'b0, 8'd0, 1'b1, 1'b0, 1'b0);
        v("z_t2",    1'b1, 1'b0, 1'b0, 1'b1, 16'd7, 1'b0, 8'd0, 1'b1, 1'b1, 1'b0);
        v("z_end",   1'b1, 1'b0, 1'b0, 1'b1, 16'd7, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0);
`else
        c_del0 = 16'd10; c_step = 16'd5; c_npts = 8'd2; c_shots = 8'd1;
        v("r_start", 1'b1, 1'b1, 1'b0, 1'b0, 16'd10, 1'b1, 8'd0, 1'b1, 1'b0, 1'b0);
        v("r_t1",    1'b1, 1'b0, 1'b0, 1'b1, 16'd10, 1'b0, 8'd0, 1'b1, 1'b0, 1'b0);
        v("r_t2",    1'b1, 1'b0, 1'b0, 1'b1, 16'd15, 1'b1, 8'd1, 1'b1, 1'b0, 1'b0);
        v("r_i2",    1'b1, 1'b0, 1'b0, 1'b0, 16'd15, 1'b0, 8'd1, 1'b1, 1'b0, 1'b0);
        v("r_t3",    1'b1, 1'b0, 1'b0, 1'b1, 16'd10, 1'b1, 8'd0, 1'b1, 1'b1, 1'b0);
        v("r_i3",    1'b1, 1'b0, 1'b0, 1'b0, 16'd10, 1'b0, 8'd0, 1'b1, 1'b0, 1'b0);
        v("r_t4",    1'b1, 1'b0, 1'b0, 1'b1, 16'd15, 1'b1, 8'd1, 1'b1, 1'b0, 1'b0);
        v("r_i4",    1'b1, 1'b0, 1'b0, 1'b0, 16'd15, 1'b0, 8'd1, 1'b1, 1'b0, 1'b0);
        v("r_t5",    1'b1, 1'b0, 1'b0, 1'b1, 16'd10, 1'b1, 8'd0, 1'b1, 1'b1, 1'b0);
        v("r_abort", 1'b1, 1'b0, 1'b1, 1'b0, 16'd10, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0);
`endif
        // Saturation, then restart clears overflow; abort on a point-advance tick
        c_del0 = 16'hFFF0; c_step = 16'h0020; c_npts = 8'd2; c_shots = 8'd1;
        v("s_start", 1'b1, 1'b1, 1'b0, 1'b0, 16'hFFF0, 1'b1, 8'd0, 1'b1, 1'b0, 1'b0);
        v("s_t1",    1'b1, 1'b0, 1'b0, 1'b1, 16'hFFF0, 1'b0, 8'd0, 1'b1, 1'b0, 1'b0);
        v("s_t2",    1'b1, 1'b0, 1'b0, 1'b1, 16'hFFFF, 1'b1, 8'd1, 1'b1, 1'b0, 1'b1);
        v("s_abort", 1'b1, 1'b0, 1'b1, 1'b0, 16'hFFFF, 1'b0, 8'd1, 1'b0, 1'b0, 1'b1);
        c_del0 = 16'd100; c_step = 16'd1; c_npts = 8'd5; c_shots = 8'd1;
        v("a_start", 1'b1, 1'b1, 1'b0, 1'b0, 16'd100, 1'b1, 8'd0, 1'b1, 1'b0, 1'b0);
        v("a_t1",    1'b1, 1'b0, 1'b0, 1'b1, 16'd100, 1'b0, 8'd0, 1'b1, 1'b0, 1'b0);
        v("a_t2",    1'b1, 1'b0, 1'b0, 1'b1, 16'd101, 1'b1, 8'd1, 1'b1, 1'b0, 1'b0);
        v("a_i2",    1'b1, 1'b0, 1'b0, 1'b0, 16'd101, 1'b0, 8'd1, 1'b1, 1'b0, 1'b0);
        v("a_t3",    1'b1, 1'b0, 1'b0, 1'b1, 16'd102, 1'b1, 8'd2, 1'b1, 1'b0, 1'b0);
        v("a_tabrt", 1'b1, 1'b0, 1'b1, 1'b1, 16'd102, 1'b0, 8'd2, 1'b0, 1'b0, 1'b0);
        v("a_itick", 1'b1, 1'b0, 1'b0, 1'b1, 16'd102, 1'b0, 8'd2, 1'b0, 1'b0, 1'b0);
        v("a_stab",  1'b1, 1'b1, 1'b1, 1'b0, 16'd102, 1'b0, 8'd2, 1'b0, 1'b0, 1'b0);
        // Reset in the middle of RUN at point 2
        v("m_start", 1'b1, 1'b1, 1'b0, 1'b0, 16'd100, 1'b1, 8'd0, 1'b1, 1'b0, 1'b0);
        v("m_t1",    1'b1, 1'b0, 1'b0, 1'b1, 16'd100, 1'b0, 8'd0, 1'b1, 1'b0, 1'b0);
        v("m_t2",    1'b1, 1'b0, 1'b0, 1'b1, 16'd101, 1'b1, 8'd1, 1'b1, 1'b0, 1'b0);
        v("m_i2",    1'b1, 1'b0, 1'b0, 1'b0, 16'd101, 1'b0, 8'd1, 1'b1, 1'b0, 1'b0);
        v("m_t3",    1'b1, 1'b0, 1'b0, 1'b1, 16'd102, 1'b1, 8'd2, 1'b1, 1'b0, 1'b0);
        v("m_rst",   1'b0, 1'b0, 1'b0, 1'b1, 16'd0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0);
        v("m_t4",    1'b1, 1'b0, 1'b0, 1'b1, 16'd0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0);
        v("m_t5",    1'b1, 1'b0, 1'b0, 1'b1, 16'd0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0);

        foreach (vecs[i]) if (vecs[i].e_load) load_expected++;

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk_pll);
            reset = vecs[i].rst_n; start = vecs[i].start; abort = vecs[i].abort;
            period_tick = vecs[i].tick;
            cfg_del0 = vecs[i].del0; cfg_step = vecs[i].step;
            cfg_npts = vecs[i].npts; cfg_shots = vecs[i].shots;
            exp_q.push_back(vecs[i]);
            @(posedge clk_pll);
            #1;
            e = exp_q.pop_front();
            checks++;
            if ({del, load, point_idx, busy, done, overflow} !==
                {e.e_del, e.e_load, e.e_idx, e.e_busy, e.e_done, e.e_ovf}) begin
                errors++;
                $display("FAIL %s: got del=%h load=%b idx=%0d busy=%b done=%b ovf=%b, want del=%h load=%b idx=%0d busy=%b done=%b ovf=%b",
                         e.name, del, load, point_idx, busy, done, overflow,
                         e.e_del, e.e_load, e.e_idx, e.e_busy, e.e_done, e.e_ovf);
            end
            if (load) load_seen++;
            if (load && load_prev) load_back_to_back++;
            load_prev = load;
        end

        checks++;
        if (load_seen != load_expected) begin
            errors++;
            $display("FAIL load_count: got %0d, want %0d", load_seen, load_expected);
        end
        checks++;
        if (load_back_to_back != 0) begin
            errors++;
            $display("FAIL load_consecutive: got %0d, want 0", load_back_to_back);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/delay_sweep_scheduler.md
# delay_sweep_scheduler

Sequences the pulse generator's inter-pulse delay through a linear sweep so echo-vs-delay curves (T2 decay) are taken without host intervention between points. Sits between the UART parameter registers and the pulse generator. Drives the generator's `del` input and its one-cycle parameter-load strobe. Advances one sweep point after a programmed number of shots, counted from the generator's period-wrap strobe.

## Interface
- No parameters; all widths are fixed to match the pulse generator.
- `clk_pll` in 1: 200 MHz PLL clock.
- `reset` in 1: synchronous, active-low.
- `start` in 1: single-cycle request to begin a sweep. Ignored unless in IDLE.
- `abort` in 1: single-cycle request that ends any sweep.
- `cfg_del0` in 16: delay for the first point, in cycles.
- `cfg_step` in 16: delay increment per point, in cycles.
- `cfg_npts` in 8: number of points. 0 is treated as 1.
- `cfg_shots` in 8: shots per point. 0 is treated as 1.
- `period_tick` in 1: one-cycle strobe when the generator's period counter wraps to 0.
- `del` out 16: delay presented to the generator.
- `load` out 1: one-cycle strobe. The generator latches `del` on this cycle.
- `point_idx` out 8: index of the current point.
- `busy` out 1: high in ARM, RUN and DONE.
- `done` out 1: one-cycle strobe when the sweep completes.
- `overflow` out 1: sticky flag; delay addition saturated.

## Operation
- States: IDLE, ARM, RUN, DONE.
- IDLE, `start`=1:
  - latch `cfg_*` into internal copies; later `cfg_*` changes are ignored until the next start.
  - `del`<=`cfg_del0`, `point_idx`<=0, shot count<=0, `overflow`<=0.
  - `load`=1 for one cycle; go to ARM.
- ARM: waits for the first `period_tick`, so shot 0 begins on a period boundary. On the tick, go to RUN with shot count 0.
- RUN, on each `period_tick`:
  - If shot count < shots-1: increment the shot count.
  - Else, if `point_idx` < npts-1:
    - `point_idx`+1, shot count<=0, `load`=1 for one cycle.
    - `del`<=`del`+step, computed at 17 bits. If bit 16 is set, `del`<=16'hFFFF and `overflow`<=1.
  - Else: go to DONE.
- DONE: `done`=1 for one cycle, then go to IDLE. `busy` falls on the IDLE cycle.
- `abort` in any non-IDLE state:
  - next state is IDLE; `busy`<=0.
  - no `done`, no `load`.
  - `del`, `point_idx` and `overflow` hold their values.
- Priority: `abort` > `period_tick` > `start`.
  - `start` together with `abort` in IDLE does nothing.
  - `start` while busy is dropped, not queued.
- `period_tick` in IDLE or DONE is ignored.

## Timing
- Reset values: state IDLE; `del`=0, `load`=0, `point_idx`=0, `busy`=0, `done`=0, `overflow`=0.
- Reset asserted mid-sweep returns to these values on the next edge. No `done` is produced.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- `start` at edge N:
  - `busy`=1, `load`=1 and `del`=`cfg_del0` are valid after edge N+1.
  - `load` is low after edge N+2.
- Point-advance tick at edge T: the new `del`, `point_idx` and `load`=1 are valid after edge T+1. The generator therefore applies the new delay from the following period.
- Final tick at edge T:
  - state DONE with `done`=1 after T+1.
  - `busy`=0 after T+2.
- A single sweep lasts (npts × shots) ticks after the arming tick.
- `load` never asserts on two consecutive cycles.

## Configuration
- `SWEEP_REPEAT_EN` defined, at the end of the last point:
  - `done` pulses for one cycle.
  - `del`<=latched del0, `point_idx`<=0, `load`=1, state stays RUN.
  - the sweep repeats until `abort`. `busy` stays high. `overflow` is cleared on each restart.
  - DONE is used only in single-shot mode.
- `SWEEP_REPEAT_EN` undefined: single sweep as specified above, then IDLE.

## Test plan
- Basic sweep: del0=200, step=50, npts=3, shots=2, `start`, then 7 ticks.
  - `del` sequence 200, 250, 300.
  - `load` pulses: 3 (after start, after tick 3, after tick 5).
  - `done` one cycle after tick 7; `busy` low the cycle after that.
- Zero config: npts=0, shots=0, `start`, 2 ticks. Behaves as 1×1: `done` after tick 2; exactly one `load`.
- Saturation: del0=16'hFFF0, step=16'h0020, npts=2, shots=1. Second point gives `del`=16'hFFFF and `overflow`=1. A subsequent `start` clears `overflow`.
- Abort and priority:
  - `abort` in the same cycle as a point-advance tick: next state IDLE; `del`/`point_idx` unchanged; no `load`, no `done`.
  - `start`+`abort` together in IDLE: `busy` stays 0.
- Reset mid-RUN with `point_idx`=2: all outputs go to reset values next edge; later ticks produce nothing.
- With `SWEEP_REPEAT_EN`: npts=2, shots=1, 5 ticks.
  - `done` after tick 3.
  - `del` returns to del0 with `load`=1; `busy` stays 1.
  - `point_idx` sequence 0, 1, 0, 1.
